multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I-subset core. Replaces single-cycle decode: one shared
//  ALU and one unified instruction/data memory port, with memory handshake (mem_req/mem_ready).

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer (master) and the
// datapath plus unified memory port (slave).
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alusrc_a;
    logic [1:0] alusrc_b;
    logic [3:0] aluctl;
    logic       regwrite;
    logic [1:0] wb_sel;
    logic       fault;
    logic       fault_illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc_a, alusrc_b,
        output aluctl, regwrite, wb_sel, fault, fault_illegal, state
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc_a, alusrc_b,
        input  aluctl, regwrite, wb_sel, fault, fault_illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset sequencer: one state per clock through fetch/decode/execute/
// memory/writeback, with memory-wait timeout and a sticky fault state.
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        StFetch   = 4'd0,  StDecode = 4'd1,  StExecR = 4'd2,  StExecI = 4'd3,
        StAluWb   = 4'd4,  StBranch = 4'd5,  StJal   = 4'd6,  StJalr  = 4'd7,
        StLui     = 4'd8,  StAuipc  = 4'd9,  StMemAddr = 4'd10, StMemRd = 4'd11,
        StMemWr   = 4'd12, StMemWb  = 4'd13, StFault = 4'd15
    } state_e;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpB     = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluXor = 4'b0011;
    localparam logic [3:0] AluSlt = 4'b0111;

    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CntW-1:0] WaitLast = CntW'(MAX_WAIT - 1);

    state_e          state_q, state_d, dec_next;
    logic [CntW-1:0] wait_q;
    logic            illegal_q;
    logic            f3_legal, r_legal, br_legal, mem_wait, timeout;
    logic [3:0]      f3_alu, r_alu;

    // Instruction legality and ALU function decode.
    always_comb begin
        f3_alu   = AluAdd;
        f3_legal = 1'b1;
        case (bus.funct3)
            3'b000:  f3_alu = AluAdd;
            3'b111:  f3_alu = AluAnd;
            3'b110:  f3_alu = AluOr;
            3'b100:  f3_alu = AluXor;
            3'b010:  f3_alu = AluSlt;
            default: f3_legal = 1'b0;
        endcase
        r_legal  = f3_legal && ((bus.funct7 == 7'b0000000) ||
                                (bus.funct3 == 3'b000 && bus.funct7 == 7'b0100000));
        r_alu    = (bus.funct7 == 7'b0100000) ? AluSub : f3_alu;
        br_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);

        case (bus.opcode)
            OpR:             dec_next = r_legal ? StExecR : StFault;
            OpI:             dec_next = f3_legal ? StExecI : StFault;
            OpB:             dec_next = br_legal ? StBranch : StFault;
            OpJal:           dec_next = StJal;
            OpJalr:          dec_next = StJalr;
            OpLui:           dec_next = StLui;
            OpAuipc:         dec_next = StAuipc;
            OpLoad, OpStore: dec_next = StMemAddr;
            default:         dec_next = StFault;
        endcase
    end

    // Next state; mem_ready takes priority over an expiring wait limit.
    always_comb begin
        mem_wait = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr)) &&
                   !bus.mem_ready;
        timeout  = mem_wait && (MAX_WAIT != 0) && (wait_q == WaitLast);
        state_d  = state_q;
        case (state_q)
            StFetch:   state_d = bus.mem_ready ? StDecode : (timeout ? StFault : StFetch);
            StDecode:  state_d = dec_next;
            StExecR, StExecI, StLui, StAuipc: state_d = StAluWb;
            StAluWb, StBranch, StJal, StJalr, StMemWb: state_d = StFetch;
            StMemAddr: state_d = (bus.opcode == OpLoad) ? StMemRd : StMemWr;
            StMemRd:   state_d = bus.mem_ready ? StMemWb : (timeout ? StFault : StMemRd);
            StMemWr:   state_d = bus.mem_ready ? StFetch : (timeout ? StFault : StMemWr);
            default:   state_d = StFault;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (mem_wait) begin
                wait_q <= wait_q + CntW'(1);
            end
            if (timeout && state_d == StFault) begin
                illegal_q <= 1'b0;
            end else if (state_q != StFault && state_d == StFault) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Moore decode of the registered state; reset forces every output low at once.
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_src        = 1'b0;
        bus.alusrc_a      = 2'b00;
        bus.alusrc_b      = 2'b00;
        bus.aluctl        = AluAdd;
        bus.regwrite      = 1'b0;
        bus.wb_sel        = 2'b00;
        bus.fault         = 1'b0;
        bus.fault_illegal = 1'b0;
        bus.state         = state_q;
        case (state_q)
            StFetch: begin
                bus.mem_req  = 1'b1;
                bus.alusrc_b = 2'b01;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            StDecode:  begin bus.alusrc_a = 2'b01; bus.alusrc_b = 2'b10; end
            StExecR:   begin bus.alusrc_a = 2'b10; bus.aluctl = r_alu; end
            StExecI:   begin bus.alusrc_a = 2'b10; bus.alusrc_b = 2'b10; bus.aluctl = f3_alu; end
            StAluWb:   bus.regwrite = 1'b1;
            StBranch: begin
                bus.alusrc_a = 2'b10;
                bus.aluctl   = AluSub;
                bus.pc_write = (bus.funct3 == 3'b000) ? bus.zero : !bus.zero;
                bus.pc_src   = 1'b1;
            end
            StJal: begin
                bus.regwrite = 1'b1;
                bus.wb_sel   = 2'b10;
                bus.pc_write = 1'b1;
                bus.pc_src   = 1'b1;
            end
            StJalr: begin
                bus.alusrc_a = 2'b10;
                bus.alusrc_b = 2'b10;
                bus.pc_write = 1'b1;
                bus.regwrite = 1'b1;
                bus.wb_sel   = 2'b10;
            end
            StLui:     begin bus.alusrc_a = 2'b11; bus.alusrc_b = 2'b10; end
            StAuipc:   begin bus.alusrc_a = 2'b01; bus.alusrc_b = 2'b10; end
            StMemAddr: begin bus.alusrc_a = 2'b10; bus.alusrc_b = 2'b10; end
            StMemRd:   begin bus.mem_req = 1'b1; bus.iord = 1'b1; end
            StMemWr:   begin bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.iord = 1'b1; end
            StMemWb:   begin bus.regwrite = 1'b1; bus.wb_sel = 2'b01; end
            default: begin
                bus.fault         = 1'b1;
                bus.fault_illegal = illegal_q;
            end
        endcase
        if (reset) begin
            bus.mem_req       = 1'b0;
            bus.mem_we        = 1'b0;
            bus.iord          = 1'b0;
            bus.ir_write      = 1'b0;
            bus.pc_write      = 1'b0;
            bus.pc_src        = 1'b0;
            bus.alusrc_a      = 2'b00;
            bus.alusrc_b      = 2'b00;
            bus.aluctl        = 4'b0000;
            bus.regwrite      = 1'b0;
            bus.wb_sel        = 2'b00;
            bus.fault         = 1'b0;
            bus.fault_illegal = 1'b0;
            bus.state         = 4'd0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction walks, memory waits, timeout,
// illegal-instruction traps and mid-instruction reset.
module tb_multicycle_ctrl;
    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpB     = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] XOR = 4'b0011;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Packs {req,we,iord,ir_write,pc_write,pc_src,a,b,aluctl,regwrite,wb_sel,fault,fault_illegal}.
    function automatic logic [18:0] ctl(input logic req, input logic we, input logic io,
                                        input logic irw, input logic pcw, input logic pcs,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [3:0] alu, input logic rw,
                                        input logic [1:0] wb, input logic f, input logic fi);
        return {req, we, io, irw, pcw, pcs, a, b, alu, rw, wb, f, fi};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [18:0] c);
        logic [22:0] obs;
        logic [22:0] exp;
        #1;
        obs = {bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
               bus.pc_src, bus.alusrc_a, bus.alusrc_b, bus.aluctl, bus.regwrite, bus.wb_sel,
               bus.fault, bus.fault_illegal};
        exp = {st, c};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [18:0] c_fetch, c_fwait, c_dec, c_aluwb, c_memrd, c_fill, c_fto;
        c_fetch = ctl(1, 0, 0, 1, 1, 0, 2'b00, 2'b01, ADD, 0, 2'b00, 0, 0);
        c_fwait = ctl(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, ADD, 0, 2'b00, 0, 0);
        c_dec   = ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, ADD, 0, 2'b00, 0, 0);
        c_aluwb = ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 1, 2'b00, 0, 0);
        c_memrd = ctl(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, ADD, 0, 2'b00, 0, 0);
        c_fill  = ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 0, 2'b00, 1, 1);
        c_fto   = ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 0, 2'b00, 1, 0);

        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        bus.opcode = 7'd0;
        bus.funct3 = 3'd0;
        bus.funct7 = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 4'd0, 19'd0);
        reset = 1'b0;

        // addi x1,x0,5
        bus.opcode = OpI; bus.funct3 = 3'b000; bus.mem_ready = 1'b1;
        chk("addi_fetch", 4'd0, c_fetch); step();
        chk("addi_decode", 4'd1, c_dec); step();
        chk("addi_exec", 4'd3, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, ADD, 0, 2'b00, 0, 0)); step();
        chk("addi_wb", 4'd4, c_aluwb); step();

        // beq then bne, both with zero=1
        bus.opcode = OpB; bus.funct3 = 3'b000; bus.zero = 1'b1;
        chk("beq_fetch", 4'd0, c_fetch); step(); step();
        chk("beq_taken", 4'd5, ctl(0, 0, 0, 0, 1, 1, 2'b10, 2'b00, SUB, 0, 2'b00, 0, 0)); step();
        bus.funct3 = 3'b001;
        chk("bne_fetch", 4'd0, c_fetch); step(); step();
        chk("bne_not_taken", 4'd5, ctl(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, SUB, 0, 2'b00, 0, 0));
        step();

        // R-type sub, I-type xori
        bus.opcode = OpR; bus.funct3 = 3'b000; bus.funct7 = 7'b0100000;
        chk("sub_fetch", 4'd0, c_fetch); step(); step();
        chk("sub_exec", 4'd2, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, SUB, 0, 2'b00, 0, 0)); step();
        chk("sub_wb", 4'd4, c_aluwb); step();
        bus.opcode = OpI; bus.funct3 = 3'b100; bus.funct7 = 7'b0000000;
        step(); step();
        chk("xori_exec", 4'd3, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, XOR, 0, 2'b00, 0, 0));
        step(); step();

        // jal, jalr, lui
        bus.opcode = OpJal; step(); step();
        chk("jal", 4'd6, ctl(0, 0, 0, 0, 1, 1, 2'b00, 2'b00, ADD, 1, 2'b10, 0, 0)); step();
        bus.opcode = OpJalr; bus.funct3 = 3'b000; step(); step();
        chk("jalr", 4'd7, ctl(0, 0, 0, 0, 1, 0, 2'b10, 2'b10, ADD, 1, 2'b10, 0, 0)); step();
        bus.opcode = OpLui; step(); step();
        chk("lui", 4'd8, ctl(0, 0, 0, 0, 0, 0, 2'b11, 2'b10, ADD, 0, 2'b00, 0, 0)); step();
        chk("lui_wb", 4'd4, c_aluwb); step();

        // lw with three wait cycles in MEM_RD
        bus.opcode = OpLoad; bus.funct3 = 3'b010; step(); step();
        chk("lw_addr", 4'd10, ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, ADD, 0, 2'b00, 0, 0));
        bus.mem_ready = 1'b0; step();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait", 4'd11, c_memrd); step();
        end
        bus.mem_ready = 1'b1;
        chk("lw_ready", 4'd11, c_memrd); step();
        chk("lw_wb", 4'd13, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 1, 2'b01, 0, 0)); step();
        chk("lw_next_fetch", 4'd0, c_fetch);

        // sw stalled in MEM_WR, then aborted by reset
        bus.opcode = OpStore; step(); step();
        bus.mem_ready = 1'b0; step();
        chk("sw_memwr", 4'd12, ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, ADD, 0, 2'b00, 0, 0));
        step(); step();
        reset = 1'b1;
        chk("sw_reset_abort", 4'd0, 19'd0);
        step();
        reset = 1'b0;
        chk("post_reset_fetch", 4'd0, c_fwait);
        for (int i = 2; i <= 14; i++) begin
            step();
            chk("fetch_wait", 4'd0, c_fwait);
        end
        step();
        bus.mem_ready = 1'b1;
        chk("ready_on_15th", 4'd0, c_fetch); step();
        bus.opcode = OpI; bus.funct3 = 3'b000;
        chk("no_fault_decode", 4'd1, c_dec); step(); step(); step();

        // fetch timeout after 15 wait cycles
        bus.mem_ready = 1'b0;
        repeat (14) step();
        chk("timeout_15th", 4'd0, c_fwait); step();
        chk("timeout_fault", 4'd15, c_fto);
        bus.mem_ready = 1'b1; step();
        chk("timeout_sticky", 4'd15, c_fto);
        reset = 1'b1; step(); reset = 1'b0;

        // illegal opcode
        bus.opcode = 7'b0000000; step();
        chk("illop_decode", 4'd1, c_dec); step();
        chk("illop_fault", 4'd15, c_fill); step(); step();
        chk("illop_sticky", 4'd15, c_fill);
        reset = 1'b1; step(); reset = 1'b0;
        chk("fault_cleared", 4'd0, c_fetch);

        // illegal R funct7
        bus.opcode = OpR; bus.funct3 = 3'b000; bus.funct7 = 7'b0000001;
        step(); step();
        chk("illfunct_fault", 4'd15, c_fill);
        reset = 1'b1; step(); reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
